// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding encodings,
// mult/div defaults, shadow-stage record and the source-match helper.
package pipeline_hazard_controller_pkg;

    localparam int MD_CYCLES_DEFAULT = 8;
    localparam int MD_CNT_W          = 5;
    localparam int STALL_CNT_W       = 16;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_EX  = 2'b01,
        FWD_MEM = 2'b10,
        FWD_WB  = 2'b11
    } fwd_sel_e;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

    typedef struct packed {
        logic [4:0] dest;
        logic       rf_enable;
        logic       load;
    } shadow_t;

    localparam shadow_t SHADOW_BUBBLE = '0;

    // r0 is hardwired to zero, so a write to it never produces a forwardable value.
    function automatic logic stage_hits(shadow_t stage, logic [4:0] src, logic uses);
        return uses && stage.rf_enable && (stage.dest == src) && (stage.dest != 5'd0);
    endfunction

    function automatic fwd_sel_e fwd_select(shadow_t ex, shadow_t mem, shadow_t wb,
                                            logic [4:0] src, logic uses);
        fwd_sel_e sel;
        sel = FWD_RF;
        if (stage_hits(ex, src, uses))
            sel = FWD_EX;
        else if (stage_hits(mem, src, uses))
            sel = FWD_MEM;
        else if (stage_hits(wb, src, uses))
            sel = FWD_WB;
        return sel;
    endfunction

endpackage

// File: rtl/pipeline_hazard_controller_md_busy_counter.sv
// HI/LO mult/div occupancy tracker: IDLE/BUSY state machine with a down-counter
// that keeps the unit busy for MD_CYCLES cycles after each issue.
module md_busy_counter
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int MD_CYCLES = MD_CYCLES_DEFAULT
) (
    input  logic Clk,
    input  logic Reset,
    input  logic md_start,
    input  logic stall,
    output logic md_busy
);

    md_state_e             state_q, state_d;
    logic [MD_CNT_W-1:0]   cnt_q, cnt_d;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        // NOTE: hold-value defaults first so every path assigns both, avoiding latches.
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MD_IDLE: begin
                // A start held back by a hazard stall is not issued that cycle.
                if (md_start && !stall) begin
                    state_d = MD_RUN;
                    cnt_d   = MD_CNT_W'(MD_CYCLES);
                end
            end
            MD_RUN: begin
                if (cnt_q == MD_CNT_W'(1)) begin
                    state_d = MD_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - MD_CNT_W'(1);
                end
            end
            default: begin
                state_d = MD_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign md_busy = (state_q == MD_RUN);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Hazard unit for a 5-stage pipeline: operand forwarding, load-use and mult/div
// stalls, shadow EX/MEM/WB destination tracking and a saturating stall counter.
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int MD_CYCLES = MD_CYCLES_DEFAULT
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [4:0]             ID_RS,
    input  logic [4:0]             ID_RT,
    input  logic                   ID_USES_RS,
    input  logic                   ID_USES_RT,
    input  logic [4:0]             ID_DEST,
    input  logic                   ID_RF_ENABLE,
    input  logic                   ID_LOAD_INSTR,
    input  logic                   ID_MD_START,
    input  logic                   ID_HILO_READ,
    output logic                   PC_LE,
    output logic                   IFID_LE,
    output logic                   IDEX_NOP,
    output logic [1:0]             FWD_A,
    output logic [1:0]             FWD_B,
    output logic                   MD_BUSY,
    output logic [STALL_CNT_W-1:0] STALL_COUNT
);

    shadow_t ex_q, mem_q, wb_q;
    shadow_t id_entry;
    logic    load_use_stall;
    logic    md_stall;
    logic    stall;

    assign id_entry = '{dest: ID_DEST, rf_enable: ID_RF_ENABLE, load: ID_LOAD_INSTR};

    // Forwarding is reported even in a stall cycle; the bubble makes it harmless.
    assign FWD_A = fwd_select(ex_q, mem_q, wb_q, ID_RS, ID_USES_RS);
    assign FWD_B = fwd_select(ex_q, mem_q, wb_q, ID_RT, ID_USES_RT);

    // A load in EX has no data until MEM, so its consumer in ID must wait one cycle.
    assign load_use_stall = ex_q.load
                          && (stage_hits(ex_q, ID_RS, ID_USES_RS)
                              || stage_hits(ex_q, ID_RT, ID_USES_RT));

    assign md_stall = MD_BUSY && (ID_HILO_READ || ID_MD_START);
    assign stall    = load_use_stall || md_stall;

    assign PC_LE    = !stall;
    assign IFID_LE  = !stall;
    assign IDEX_NOP = stall;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ex_q  <= SHADOW_BUBBLE;
            mem_q <= SHADOW_BUBBLE;
            wb_q  <= SHADOW_BUBBLE;
        end else begin
            // NOTE: non-blocking so MEM/WB take the pre-edge values of the stage ahead.
            ex_q  <= stall ? SHADOW_BUBBLE : id_entry;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            STALL_COUNT <= '0;
        end else if (stall && (STALL_COUNT != '1)) begin
            STALL_COUNT <= STALL_COUNT + STALL_CNT_W'(1);
        end
    end

    md_busy_counter #(
        .MD_CYCLES (MD_CYCLES)
    ) u_md_busy_counter (
        .Clk      (Clk),
        .Reset    (Reset),
        .md_start (ID_MD_START),
        .stall    (stall),
        .md_busy  (MD_BUSY)
    );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: a per-cycle vector table for
// forwarding/load-use behaviour, then hand-written mult/div, reset and saturation runs.
module tb_pipeline_hazard_controller;

    logic        Clk;
    logic        Reset;
    logic [4:0]  ID_RS, ID_RT, ID_DEST;
    logic        ID_USES_RS, ID_USES_RT, ID_RF_ENABLE, ID_LOAD_INSTR;
    logic        ID_MD_START, ID_HILO_READ;
    logic        PC_LE, IFID_LE, IDEX_NOP, MD_BUSY;
    logic [1:0]  FWD_A, FWD_B;
    logic [15:0] STALL_COUNT;

    int checks = 0;
    int errors = 0;

    pipeline_hazard_controller #(
        .MD_CYCLES (8)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .ID_RS         (ID_RS),
        .ID_RT         (ID_RT),
        .ID_USES_RS    (ID_USES_RS),
        .ID_USES_RT    (ID_USES_RT),
        .ID_DEST       (ID_DEST),
        .ID_RF_ENABLE  (ID_RF_ENABLE),
        .ID_LOAD_INSTR (ID_LOAD_INSTR),
        .ID_MD_START   (ID_MD_START),
        .ID_HILO_READ  (ID_HILO_READ),
        .PC_LE         (PC_LE),
        .IFID_LE       (IFID_LE),
        .IDEX_NOP      (IDEX_NOP),
        .FWD_A         (FWD_A),
        .FWD_B         (FWD_B),
        .MD_BUSY       (MD_BUSY),
        .STALL_COUNT   (STALL_COUNT)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [4:0]  rs;
        logic        uses_rs;
        logic [4:0]  rt;
        logic        uses_rt;
        logic [4:0]  dest;
        logic        rf_en;
        logic        load;
        logic        exp_pc_le;
        logic [1:0]  exp_fwd_a;
        logic [1:0]  exp_fwd_b;
        logic [15:0] exp_sc;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    function automatic vec_t mk(logic [4:0] rs, logic urs, logic [4:0] rt, logic urt,
                                logic [4:0] dest, logic rf, logic ld,
                                logic pc, logic [1:0] fa, logic [1:0] fb, logic [15:0] sc);
        vec_t v;
        v.rs = rs; v.uses_rs = urs; v.rt = rt; v.uses_rt = urt;
        v.dest = dest; v.rf_en = rf; v.load = ld;
        v.exp_pc_le = pc; v.exp_fwd_a = fa; v.exp_fwd_b = fb; v.exp_sc = sc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        ID_RS = '0; ID_RT = '0; ID_USES_RS = 0; ID_USES_RT = 0;
        ID_DEST = '0; ID_RF_ENABLE = 0; ID_LOAD_INSTR = 0;
        ID_MD_START = 0; ID_HILO_READ = 0;
    endtask

    task automatic check_ctrl(input string tag, input logic pc, input logic busy,
                              input logic [15:0] sc);
        check({tag, ".PC_LE"}, 32'(PC_LE), 32'(pc));
        check({tag, ".IFID_LE"}, 32'(IFID_LE), 32'(pc));
        check({tag, ".IDEX_NOP"}, 32'(IDEX_NOP), 32'(!pc));
        check({tag, ".MD_BUSY"}, 32'(MD_BUSY), 32'(busy));
        check({tag, ".STALL_COUNT"}, 32'(STALL_COUNT), 32'(sc));
    endtask

    logic [15:0] exp_sc;
    logic [15:0] model_sc;

    initial begin
        // rs, urs, rt, urt, dest, rf, ld | pc, fwd_a, fwd_b, stall_count
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0); // reset state
        vecs[1]  = mk(0, 0, 0, 0, 5, 1, 0, 1, 2'b00, 2'b00, 0); // writes r5
        vecs[2]  = mk(5, 1, 0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 0); // r5 in EX
        vecs[3]  = mk(5, 1, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0); // r5 in MEM
        vecs[4]  = mk(5, 1, 0, 0, 0, 0, 0, 1, 2'b11, 2'b00, 0); // r5 in WB
        vecs[5]  = mk(5, 1, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0); // retired
        vecs[6]  = mk(0, 0, 0, 0, 0, 1, 1, 1, 2'b00, 2'b00, 0); // lw r0
        vecs[7]  = mk(0, 1, 0, 1, 0, 0, 0, 1, 2'b00, 2'b00, 0); // read r0: no fwd, no stall
        vecs[8]  = mk(0, 0, 0, 0, 8, 1, 1, 1, 2'b00, 2'b00, 0); // lw r8
        vecs[9]  = mk(0, 0, 8, 1, 0, 0, 0, 0, 2'b00, 2'b01, 0); // load-use stall
        vecs[10] = mk(0, 0, 8, 1, 0, 0, 0, 1, 2'b00, 2'b10, 1); // released, from MEM
        vecs[11] = mk(0, 0, 0, 0, 9, 1, 0, 1, 2'b00, 2'b00, 1); // writes r9
        vecs[12] = mk(0, 0, 9, 1, 9, 1, 0, 1, 2'b00, 2'b01, 1); // reads+writes r9
        vecs[13] = mk(9, 1, 9, 0, 0, 0, 0, 1, 2'b01, 2'b00, 1); // EX beats MEM; unused rt
        vecs[14] = mk(0, 0, 0, 0, 7, 1, 1, 1, 2'b00, 2'b00, 1); // lw r7
        vecs[15] = mk(7, 0, 7, 0, 0, 0, 0, 1, 2'b00, 2'b00, 1); // r7 not used: no stall
        vecs[16] = mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 1);

        clear_inputs();
        Reset = 1'b1;
        #12 Reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge Clk);
            ID_RS = vecs[i].rs; ID_USES_RS = vecs[i].uses_rs;
            ID_RT = vecs[i].rt; ID_USES_RT = vecs[i].uses_rt;
            ID_DEST = vecs[i].dest; ID_RF_ENABLE = vecs[i].rf_en;
            ID_LOAD_INSTR = vecs[i].load;
            ID_MD_START = 0; ID_HILO_READ = 0;
            #1;
            check_ctrl($sformatf("vec%0d", i), vecs[i].exp_pc_le, 1'b0, vecs[i].exp_sc);
            check($sformatf("vec%0d.FWD_A", i), 32'(FWD_A), 32'(vecs[i].exp_fwd_a));
            check($sformatf("vec%0d.FWD_B", i), 32'(FWD_B), 32'(vecs[i].exp_fwd_b));
        end
        exp_sc = 16'd1;

        // mult/div issue followed by mfhi: eight busy, stalled cycles
        @(negedge Clk);
        clear_inputs();
        ID_MD_START = 1;
        #1 check_ctrl("md_issue", 1'b1, 1'b0, exp_sc);
        for (int i = 1; i <= 8; i++) begin
            @(negedge Clk);
            ID_MD_START = 0; ID_HILO_READ = 1;
            #1 check_ctrl($sformatf("mfhi_busy%0d", i), 1'b0, 1'b1, exp_sc + 16'(i - 1));
        end
        @(negedge Clk);
        exp_sc = exp_sc + 16'd8;
        #1 check_ctrl("mfhi_release", 1'b1, 1'b0, exp_sc);

        // back-to-back starts: second one waits, then issues after the idle edge
        @(negedge Clk);
        ID_HILO_READ = 0; ID_MD_START = 1;
        #1 check_ctrl("md2_issue", 1'b1, 1'b0, exp_sc);
        for (int i = 1; i <= 8; i++) begin
            @(negedge Clk);
            #1 check_ctrl($sformatf("md2_held%0d", i), 1'b0, 1'b1, exp_sc + 16'(i - 1));
        end
        @(negedge Clk);
        exp_sc = exp_sc + 16'd8;
        #1 check_ctrl("md3_issue", 1'b1, 1'b0, exp_sc);
        @(negedge Clk);
        ID_MD_START = 0;
        #1 check_ctrl("md3_busy1", 1'b1, 1'b1, exp_sc);
        @(negedge Clk);
        #1 check_ctrl("md3_busy2", 1'b1, 1'b1, exp_sc);

        // asynchronous reset in busy cycle 3, between clock edges
        @(negedge Clk);
        ID_HILO_READ = 1;
        #1 check_ctrl("md3_busy3", 1'b0, 1'b1, exp_sc);
        #1 Reset = 1'b1;
        #1 check_ctrl("async_reset", 1'b1, 1'b0, 16'd0);
        check("async_reset.FWD_A", 32'(FWD_A), 32'd0);
        #1 Reset = 1'b0;
        @(negedge Clk);
        #1 check_ctrl("post_reset", 1'b1, 1'b0, 16'd0);

        // continuous mult/div requests: stall 8 of every 9 cycles until saturation
        model_sc = 16'd0;
        for (int k = 0; k < 74000; k++) begin
            @(negedge Clk);
            ID_HILO_READ = 0; ID_MD_START = 1;
            #1;
            if ((k % 4096 == 0) || (model_sc >= 16'hFFFC) || (k == 73999))
                check($sformatf("sat_k%0d", k), 32'(STALL_COUNT), 32'(model_sc));
            if ((k % 9 != 0) && (model_sc != 16'hFFFF))
                model_sc = model_sc + 16'd1;
        end
        check("sat_final_model", 32'(STALL_COUNT), 32'h0000_FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
